ntr_tx: RTL and testbench

NTR_TX -- requirements
Module: ntr_tx

---
 rtl/ntr_pkg.sv | 14 +
 rtl/ntr_edge_sync.sv | 33 +++
 rtl/ntr_tx.sv | 110 +++++++++++
 tb/tb_ntr_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntr_pkg.sv
// Shared definitions for the cartridge-bus (NTR) command receiver and response transmitter.
package ntr_pkg;

   localparam logic [7:0]  NTR_IDLE_BYTE = 8'hFF;
   localparam int unsigned NTR_CMD_BYTES = 8;

   typedef enum logic [1:0] {
      NTR_IDLE  = 2'd0,
      NTR_LOAD  = 2'd1,
      NTR_SEND  = 2'd2,
      NTR_DRAIN = 2'd3
   } ntr_state_t;

endpackage

// File: rtl/ntr_edge_sync.sv
// Synchronizes the host ntr_clk into the clk domain and emits one-cycle edge strobes.
module ntr_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ntr_clk,
   output logic fall_pulse,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   // Synchronizer chain, previous-value flop and registered strobes; idle level is 1
   always_ff @(posedge clk) begin
      if (rst) begin
         sync       <= '1;
         prev       <= 1'b1;
         fall_pulse <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         sync[0] <= ntr_clk;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync[i] <= sync[i-1];
         end
         prev       <= sync[SYNC_STAGES-1];
         fall_pulse <= prev & ~sync[SYNC_STAGES-1];
         rise_pulse <= ~prev & sync[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/ntr_tx.sv
// NTR response transmitter: streams resp_len bytes toward the host, one per ntr_clk fall.
module ntr_tx
   import ntr_pkg::*;
#(
   parameter int unsigned LEN_W       = 13,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ntr_clk,
   output logic [7:0]       ntr_data_out,
   output logic             ntr_data_oe,
   input  logic             start,
   input  logic [LEN_W-1:0] resp_len,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             busy,
   output logic             underrun
);

   ntr_state_t       state;
   logic [LEN_W-1:0] remaining;
   logic [7:0]       hold;
   logic             full;
   logic             fall_pulse;
   logic             rise_pulse;
   logic             fill;

   ntr_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk        (clk),
      .rst        (rst),
      .ntr_clk    (ntr_clk),
      .fall_pulse (fall_pulse),
      .rise_pulse (rise_pulse)
   );

   // Holding register accepts a byte only while a response still needs bytes
   assign tx_ready = ((state == NTR_LOAD) || (state == NTR_SEND)) && !full;
   assign busy     = (state != NTR_IDLE);
   assign fill     = tx_valid && tx_ready;

   // Response FSM, holding register and registered pad outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= NTR_IDLE;
         remaining    <= '0;
         hold         <= '0;
         full         <= 1'b0;
         ntr_data_out <= NTR_IDLE_BYTE;
         ntr_data_oe  <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         case (state)
            NTR_IDLE: begin
               ntr_data_oe  <= 1'b0;
               ntr_data_out <= NTR_IDLE_BYTE;
               full         <= 1'b0;
               if (start) begin
                  underrun <= 1'b0;
                  if (resp_len != '0) begin
                     remaining   <= resp_len;
                     ntr_data_oe <= 1'b1;
                     state       <= NTR_LOAD;
                  end
               end
            end
            NTR_LOAD: begin
               if (fall_pulse && full) begin
                  ntr_data_out <= hold;
                  full         <= 1'b0;
                  if (remaining != '0) remaining <= remaining - LEN_W'(1);
                  state <= (remaining == LEN_W'(1)) ? NTR_DRAIN : NTR_SEND;
               end
            end
            NTR_SEND: begin
               // An empty holder at a fall skips the byte rather than stalling the host
               if (fall_pulse) begin
                  if (full) begin
                     ntr_data_out <= hold;
                  end else begin
                     ntr_data_out <= NTR_IDLE_BYTE;
                     underrun     <= 1'b1;
                  end
                  full <= 1'b0;
                  if (remaining != '0) remaining <= remaining - LEN_W'(1);
                  if (remaining <= LEN_W'(1)) state <= NTR_DRAIN;
               end
            end
            NTR_DRAIN: begin
               if (rise_pulse) begin
                  ntr_data_oe  <= 1'b0;
                  ntr_data_out <= NTR_IDLE_BYTE;
                  full         <= 1'b0;
                  state        <= NTR_IDLE;
               end
            end
            default: state <= NTR_IDLE;
         endcase
         // A fill lands after any consume in the same cycle so the new byte is kept
         if (fill) begin
            hold <= tx_data;
            full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ntr_tx.sv
// Directed self-checking bench for ntr_tx.
module tb_ntr_tx;

   localparam int unsigned LEN_W = 13;

   logic             clk = 1'b0;
   logic             rst;
   logic             ntr_clk;
   logic [7:0]       ntr_data_out;
   logic             ntr_data_oe;
   logic             start;
   logic [LEN_W-1:0] resp_len;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             busy;
   logic             underrun;

   int n_cmp = 0;
   int n_err = 0;
   int hs_count = 0;
   logic hs_armed;
   logic [7:0] src_q[$];
   logic [7:0] b;

   ntr_tx #(.LEN_W(LEN_W), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .ntr_clk      (ntr_clk),
      .ntr_data_out (ntr_data_out),
      .ntr_data_oe  (ntr_data_oe),
      .start        (start),
      .resp_len     (resp_len),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One host ntr_clk period of 10 clk; returns the byte seen at the rising edge
   task automatic host_read(output logic [7:0] v);
      ntr_clk = 1'b0;
      repeat (5) @(negedge clk);
      ntr_clk = 1'b1;
      v = ntr_data_out;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_start(input int len);
      start    = 1'b1;
      resp_len = LEN_W'(len);
      @(negedge clk);
      start    = 1'b0;
      resp_len = '0;
   endtask

   // Data source: presents the queue head; a handshake seen at a negedge completes at the next posedge
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      hs_armed = 1'b0;
      forever begin
         @(negedge clk);
         if (hs_armed && src_q.size() > 0) begin
            void'(src_q.pop_front());
            hs_count++;
         end
         if (src_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = src_q[0];
         end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
         hs_armed = tx_valid && tx_ready && !rst;
      end
   end

   initial begin
      rst      = 1'b1;
      ntr_clk  = 1'b1;
      start    = 1'b0;
      resp_len = '0;
      repeat (3) @(negedge clk);
      check("rst_oe", 32'(ntr_data_oe), 32'd0);
      check("rst_data", 32'(ntr_data_out), 32'hFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_no_spurious", 32'(busy), 32'd0);

      // Basic 4-byte response
      src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      repeat (2) @(negedge clk);
      do_start(4);
      check("s1_busy", 32'(busy), 32'd1);
      check("s1_oe", 32'(ntr_data_oe), 32'd1);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            ntr_clk = 1'b0;
            repeat (5) @(negedge clk);
            check("s1_oe_before_last_rise", 32'(ntr_data_oe), 32'd1);
            ntr_clk = 1'b1;
            b = ntr_data_out;
            repeat (5) @(negedge clk);
         end else begin
            host_read(b);
         end
         check($sformatf("s1_byte%0d", i), 32'(b), 32'(i + 1));
      end
      check("s1_oe_after", 32'(ntr_data_oe), 32'd0);
      check("s1_data_after", 32'(ntr_data_out), 32'hFF);
      host_read(b);
      check("s1_busy_end", 32'(busy), 32'd0);
      check("s1_underrun", 32'(underrun), 32'd0);

      // Underrun: second byte missing
      src_q = '{8'hAA};
      repeat (2) @(negedge clk);
      do_start(3);
      repeat (4) @(negedge clk);
      host_read(b);
      check("s2_byte0", 32'(b), 32'hAA);
      host_read(b);
      check("s2_byte1", 32'(b), 32'hFF);
      check("s2_underrun_mid", 32'(underrun), 32'd1);
      src_q.push_back(8'hCC);
      host_read(b);
      check("s2_byte2", 32'(b), 32'hCC);
      repeat (2) @(negedge clk);
      check("s2_busy_end", 32'(busy), 32'd0);
      check("s2_underrun_sticky", 32'(underrun), 32'd1);

      // Zero-length start: accepted, clears underrun, never leaves IDLE
      do_start(0);
      for (int i = 0; i < 4; i++) begin
         check("s4_oe", 32'(ntr_data_oe), 32'd0);
         check("s4_busy", 32'(busy), 32'd0);
         check("s4_ready", 32'(tx_ready), 32'd0);
         @(negedge clk);
      end
      check("s4_underrun_cleared", 32'(underrun), 32'd0);

      // Start during SEND is ignored
      src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      repeat (2) @(negedge clk);
      do_start(4);
      repeat (4) @(negedge clk);
      host_read(b);
      check("s3_byte0", 32'(b), 32'h11);
      do_start(100);
      for (int i = 1; i < 4; i++) begin
         host_read(b);
         check($sformatf("s3_byte%0d", i), 32'(b), 32'h11 * (i + 1));
      end
      check("s3_oe_end", 32'(ntr_data_oe), 32'd0);
      check("s3_busy_end", 32'(busy), 32'd0);

      // Reset mid-response, then a fresh 2-byte response
      src_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
      repeat (2) @(negedge clk);
      do_start(8);
      repeat (4) @(negedge clk);
      host_read(b);
      check("s5_byte0", 32'(b), 32'h80);
      host_read(b);
      check("s5_byte1", 32'(b), 32'h81);
      rst = 1'b1;
      @(negedge clk);
      check("s5_rst_oe", 32'(ntr_data_oe), 32'd0);
      check("s5_rst_data", 32'(ntr_data_out), 32'hFF);
      check("s5_rst_busy", 32'(busy), 32'd0);
      check("s5_rst_ready", 32'(tx_ready), 32'd0);
      src_q.delete();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      src_q = '{8'h5A, 8'hA5};
      repeat (2) @(negedge clk);
      do_start(2);
      repeat (4) @(negedge clk);
      host_read(b);
      check("s5_new_byte0", 32'(b), 32'h5A);
      host_read(b);
      check("s5_new_byte1", 32'(b), 32'hA5);
      check("s5_new_busy_end", 32'(busy), 32'd0);

      // 16 back-to-back bytes with tx_valid held high
      repeat (2) @(negedge clk);
      hs_count = 0;
      for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h30 + i));
      repeat (2) @(negedge clk);
      do_start(16);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         host_read(b);
         check($sformatf("s6_byte%0d", i), 32'(b), 32'(8'h30 + i));
      end
      host_read(b);
      check("s6_handshakes", 32'(hs_count), 32'd16);
      check("s6_queue_left", 32'(src_q.size()), 32'd0);
      check("s6_busy_end", 32'(busy), 32'd0);
      check("s6_underrun", 32'(underrun), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
